// File: rtl/wm8731_i2s_io.sv
// WM8731 I2S bit-clock master: generates XCK/BCLK/LRCK, serialises DAC samples
// and deserialises ADC samples for a 16-bit slave codec.
module wm8731_i2s_io #(
  parameter int DATA_WIDTH = 16,
  parameter int SLOT_BITS  = 32,
  parameter int BCLK_DIV   = 16,
  parameter int MCLK_DIV   = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  output logic                  AUD_XCK,
  output logic                  AUD_BCLK,
  output logic                  AUD_ADCLRCK,
  output logic                  AUD_DACLRCK,
  input  logic                  AUD_ADCDAT,
  output logic                  AUD_DACDAT,
  output logic [DATA_WIDTH-1:0] rx_left,
  output logic [DATA_WIDTH-1:0] rx_right,
  output logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] tx_left,
  input  logic [DATA_WIDTH-1:0] tx_right,
  output logic                  tx_load
);

  localparam int DIV_W = $clog2(BCLK_DIV);
  localparam int BIT_W = $clog2(2 * SLOT_BITS);
  localparam int MCK_W = $clog2(MCLK_DIV);

  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT_C   = BIT_W'(SLOT_BITS);
  localparam logic [BIT_W-1:0] P_TWO    = BIT_W'(2);
  localparam logic [BIT_W-1:0] P_LSB    = BIT_W'(DATA_WIDTH);
  localparam logic [MCK_W-1:0] MCK_ONE  = MCK_W'(1);
  localparam logic [MCK_W-1:0] MCK_LAST = MCK_W'(MCLK_DIV / 2 - 1);

  logic [MCK_W-1:0]      mck_cnt_q, mck_cnt_d;
  logic                  xck_q, xck_d;
  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  dacdat_q, dacdat_d;
  logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_WIDTH-1:0] hold_l_q, hold_l_d;
  logic [DATA_WIDTH-1:0] hold_r_q, hold_r_d;
  logic                  adc_q, adc_d;
  logic [DATA_WIDTH-1:0] rx_sh_l_q, rx_sh_l_d;
  logic [DATA_WIDTH-1:0] rx_sh_r_q, rx_sh_r_d;
  logic [DATA_WIDTH-1:0] rx_left_q, rx_left_d;
  logic [DATA_WIDTH-1:0] rx_right_q, rx_right_d;
  logic                  rx_valid_q, rx_valid_d;

  logic                  div_wrap;
  logic                  lr_cur;
  logic [BIT_W-1:0]      p_cur;
  logic                  lr_nxt;
  logic [BIT_W-1:0]      p_nxt;
  logic                  tx_load_c;
  logic                  rx_strobe;

  assign div_wrap  = (div_cnt_q == DIV_LAST);
  assign lr_cur    = (bit_cnt_q >= SLOT_C);
  assign p_cur     = lr_cur ? (bit_cnt_q - SLOT_C) : bit_cnt_q;
  assign tx_load_c = enable && (div_cnt_q == '0) && (bit_cnt_q == '0);
  // adc_q lags the pin by one cycle, so the bit seen while div_cnt sits at the
  // rising-edge count is the one present on the pin at that edge.
  assign rx_strobe = enable && (div_cnt_q == DIV_HALF) &&
                     (p_cur >= BIT_ONE) && (p_cur <= P_LSB);

  always_comb begin
    // NOTE: every variable written here gets a default first so no path can infer a latch.
    mck_cnt_d  = mck_cnt_q + MCK_ONE;
    xck_d      = xck_q;
    div_cnt_d  = div_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    dacdat_d   = dacdat_q;
    tx_sh_d    = tx_sh_q;
    hold_l_d   = hold_l_q;
    hold_r_d   = hold_r_q;
    adc_d      = AUD_ADCDAT;
    rx_sh_l_d  = rx_sh_l_q;
    rx_sh_r_d  = rx_sh_r_q;
    rx_left_d  = rx_left_q;
    rx_right_d = rx_right_q;
    rx_valid_d = 1'b0;
    lr_nxt     = 1'b0;
    p_nxt      = '0;

    if (mck_cnt_q == MCK_LAST) begin
      mck_cnt_d = '0;
      xck_d     = ~xck_q;
    end

    if (!enable) begin
      div_cnt_d = '0;
      bit_cnt_d = '0;
      dacdat_d  = 1'b0;
    end else begin
      div_cnt_d = div_cnt_q + DIV_ONE;
      if (div_wrap) begin
        div_cnt_d = '0;
        bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BIT_ONE;
        // DACDAT is computed for the bit being entered so it moves with the BCLK fall.
        lr_nxt    = (bit_cnt_d >= SLOT_C);
        p_nxt     = lr_nxt ? (bit_cnt_d - SLOT_C) : bit_cnt_d;
        dacdat_d  = 1'b0;
        tx_sh_d   = {tx_sh_q[DATA_WIDTH-2:0], 1'b0};
        if (p_nxt == BIT_ONE) begin
          dacdat_d = lr_nxt ? hold_r_q[DATA_WIDTH-1] : hold_l_q[DATA_WIDTH-1];
          tx_sh_d  = lr_nxt ? {hold_r_q[DATA_WIDTH-2:0], 1'b0}
                            : {hold_l_q[DATA_WIDTH-2:0], 1'b0};
        end else if ((p_nxt >= P_TWO) && (p_nxt <= P_LSB)) begin
          dacdat_d = tx_sh_q[DATA_WIDTH-1];
        end
      end
    end

    if (tx_load_c) begin
      hold_l_d = tx_left;
      hold_r_d = tx_right;
    end

    if (rx_strobe) begin
      if (lr_cur) begin
        rx_sh_r_d = {rx_sh_r_q[DATA_WIDTH-2:0], adc_q};
        if (p_cur == P_LSB) begin
          rx_left_d  = rx_sh_l_q;
          rx_right_d = {rx_sh_r_q[DATA_WIDTH-2:0], adc_q};
          rx_valid_d = 1'b1;
        end
      end else begin
        rx_sh_l_d = {rx_sh_l_q[DATA_WIDTH-2:0], adc_q};
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mck_cnt_q  <= '0;
      xck_q      <= 1'b0;
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      dacdat_q   <= 1'b0;
      tx_sh_q    <= '0;
      hold_l_q   <= '0;
      hold_r_q   <= '0;
      adc_q      <= 1'b0;
      rx_sh_l_q  <= '0;
      rx_sh_r_q  <= '0;
      rx_left_q  <= '0;
      rx_right_q <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      mck_cnt_q  <= mck_cnt_d;
      xck_q      <= xck_d;
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      dacdat_q   <= dacdat_d;
      tx_sh_q    <= tx_sh_d;
      hold_l_q   <= hold_l_d;
      hold_r_q   <= hold_r_d;
      adc_q      <= adc_d;
      rx_sh_l_q  <= rx_sh_l_d;
      rx_sh_r_q  <= rx_sh_r_d;
      rx_left_q  <= rx_left_d;
      rx_right_q <= rx_right_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign AUD_XCK     = xck_q;
  assign AUD_BCLK    = (div_cnt_q >= DIV_HALF);
  assign AUD_ADCLRCK = lr_cur;
  assign AUD_DACLRCK = lr_cur;
  assign AUD_DACDAT  = dacdat_q;
  assign rx_left     = rx_left_q;
  assign rx_right    = rx_right_q;
  assign rx_valid    = rx_valid_q;
  // Gated by reset_n so the pulse is held low while reset is asserted.
  assign tx_load     = reset_n && tx_load_c;

endmodule

// File: tb/tb_wm8731_i2s_io.sv
// Directed bench for wm8731_i2s_io: clock periods, DAC serialisation, ADC
// capture through a pin-level codec model, enable drop and mid-frame reset.
module tb_wm8731_i2s_io;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        AUD_XCK, AUD_BCLK, AUD_ADCLRCK, AUD_DACLRCK, AUD_DACDAT;
  logic        AUD_ADCDAT = 1'b0;
  logic [15:0] rx_left, rx_right, tx_left, tx_right;
  logic        rx_valid, tx_load;

  wm8731_i2s_io dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .AUD_XCK    (AUD_XCK),
    .AUD_BCLK   (AUD_BCLK),
    .AUD_ADCLRCK(AUD_ADCLRCK),
    .AUD_DACLRCK(AUD_DACLRCK),
    .AUD_ADCDAT (AUD_ADCDAT),
    .AUD_DACDAT (AUD_DACDAT),
    .rx_left    (rx_left),
    .rx_right   (rx_right),
    .rx_valid   (rx_valid),
    .tx_left    (tx_left),
    .tx_right   (tx_right),
    .tx_load    (tx_load)
  );

  always #10 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Codec model and DAC decoder, tracking slot position from the BCLK/LRCK pins.
  logic [15:0] adc_l_word, adc_r_word;
  logic [15:0] dac_l_sh = '0, dac_r_sh = '0, dac_l_cap = '0, dac_r_cap = '0;
  logic [15:0] rx_l_at = '0, rx_r_at = '0;
  logic        prev_bclk = 1'b0, last_lr = 1'b0, prev_rxv = 1'b0, rxv_lr = 1'b0;
  logic [3:0]  idx;
  int pos = 0, dac_frames = 0, extra_ones = 0, rxv_count = 0, rxv_pos = 0;
  int txl_count = 0, coincide = 0, multi_high = 0, lr_diff = 0;

  always @(negedge clock) begin
    if (AUD_ADCLRCK !== AUD_DACLRCK) lr_diff++;
    if (rx_valid && tx_load) coincide++;
    if (rx_valid && prev_rxv) multi_high++;
    prev_rxv = rx_valid;
    if (tx_load) txl_count++;
    if (!reset_n || !enable) begin
      pos        = 0;
      last_lr    = 1'b0;
      prev_bclk  = 1'b0;
      AUD_ADCDAT = 1'b0;
    end else begin
      if (prev_bclk && !AUD_BCLK) begin
        if (AUD_ADCLRCK != last_lr) pos = 0;
        else pos++;
        last_lr = AUD_ADCLRCK;
        idx = 4'(16 - pos);
        if (pos >= 1 && pos <= 16) AUD_ADCDAT = last_lr ? adc_r_word[idx] : adc_l_word[idx];
        else AUD_ADCDAT = 1'b0;
      end
      if (!prev_bclk && AUD_BCLK) begin
        if (pos >= 1 && pos <= 16) begin
          if (AUD_ADCLRCK) dac_r_sh = {dac_r_sh[14:0], AUD_DACDAT};
          else dac_l_sh = {dac_l_sh[14:0], AUD_DACDAT};
        end else if (AUD_DACDAT) begin
          extra_ones++;
        end
        if (AUD_ADCLRCK && pos == 31) begin
          dac_l_cap = dac_l_sh;
          dac_r_cap = dac_r_sh;
          dac_frames++;
        end
      end
      prev_bclk = AUD_BCLK;
      if (rx_valid) begin
        rxv_count++;
        rxv_pos = pos;
        rxv_lr  = AUD_ADCLRCK;
        rx_l_at = rx_left;
        rx_r_at = rx_right;
      end
    end
  end

  function automatic logic sig(input int which);
    case (which)
      0:       return AUD_BCLK;
      1:       return AUD_ADCLRCK;
      2:       return tx_load;
      3:       return rx_valid;
      default: return AUD_XCK;
    endcase
  endfunction

  // Cycles until the next rising edge of the selected output (sampled at negedges).
  task automatic period(input int which, input int max, output int n);
    n = 0;
    while (sig(which) && n < max) begin @(negedge clock); n++; end
    while (!sig(which) && n < max) begin @(negedge clock); n++; end
  endtask

  task automatic high_len(input int which, input int max, output int n);
    n = 0;
    while (sig(which) && n < max) begin @(negedge clock); n++; end
  endtask

  task automatic wait_high(input int which, input int max, output int n);
    n = 0;
    do begin @(negedge clock); n++; end while (!sig(which) && n < max);
    if (!sig(which)) n = -1;
  endtask

  task automatic wait_frames(input int target);
    for (int i = 0; i < 1100 && dac_frames < target; i++) begin
      @(negedge clock); #1;
    end
  endtask

  function automatic logic [38:0] out_vec();
    return {AUD_XCK, AUD_BCLK, AUD_ADCLRCK, AUD_DACLRCK, AUD_DACDAT,
            rx_valid, tx_load, rx_left, rx_right};
  endfunction

  initial begin
    int n, f0, c_rx, c_tx, toggles;
    logic prev_xck;

    reset_n    = 1'b0;
    enable     = 1'b1;
    tx_left    = 16'hA5C3;
    tx_right   = 16'h0F0F;
    adc_l_word = 16'h8001;
    adc_r_word = 16'h7FFE;
    repeat (3) @(negedge clock);
    check("reset_outputs", 64'(out_vec()), 64'h0);

    // Clock generation after release
    reset_n = 1'b1;
    #1;
    check("first_tx_load", 64'(tx_load), 64'h1);
    check("xck_starts_low", 64'(AUD_XCK), 64'h0);
    period(4, 20, n);
    period(4, 20, n);
    check("xck_period", 64'(n), 64'd4);
    period(0, 40, n);
    period(0, 40, n);
    check("bclk_period", 64'(n), 64'd16);
    period(1, 2100, n);
    period(1, 2100, n);
    check("lrck_period", 64'(n), 64'd1024);
    high_len(1, 2100, n);
    check("lrck_high", 64'(n), 64'd512);
    period(2, 2100, n);
    period(2, 2100, n);
    check("tx_load_period", 64'(n), 64'd1024);

    // DAC serialisation
    wait_frames(2);
    check("dac_frames_seen", 64'(dac_frames >= 2), 64'h1);
    check("dac_left", 64'(dac_l_cap), 64'hA5C3);
    check("dac_right", 64'(dac_r_cap), 64'h0F0F);
    check("dac_idle_bits", 64'(extra_ones), 64'h0);

    // ADC capture
    check("rx_seen", 64'(rxv_count > 0), 64'h1);
    check("rx_left", 64'(rx_l_at), 64'h8001);
    check("rx_right", 64'(rx_r_at), 64'h7FFE);
    check("rx_valid_slot", 64'({rxv_lr, 8'(rxv_pos)}), 64'h110);
    c_rx = rxv_count;
    repeat (1024) @(negedge clock);
    #1;
    check("rx_valid_per_frame", 64'(rxv_count - c_rx), 64'd1);

    // Mid-frame tx change, new ADC pattern from the same frame
    wait_high(2, 1100, n);
    check("tx_load_seen", 64'(n > 0), 64'h1);
    adc_l_word = 16'h7FFF;
    adc_r_word = 16'h8000;
    repeat (300) @(negedge clock);
    tx_left  = 16'h1234;
    tx_right = 16'hFEDC;
    #1;
    f0 = dac_frames;
    wait_frames(f0 + 1);
    check("frame_a_seen", 64'(dac_frames), 64'(f0 + 1));
    check("dac_left_unchanged", 64'(dac_l_cap), 64'hA5C3);
    check("dac_right_unchanged", 64'(dac_r_cap), 64'h0F0F);
    check("rx_left_edge", 64'(rx_l_at), 64'h7FFF);
    check("rx_right_edge", 64'(rx_r_at), 64'h8000);
    wait_frames(f0 + 2);
    check("frame_b_seen", 64'(dac_frames), 64'(f0 + 2));
    check("dac_left_new", 64'(dac_l_cap), 64'h1234);
    check("dac_right_new", 64'(dac_r_cap), 64'hFEDC);
    tx_left  = 16'hA5C3;
    tx_right = 16'h0F0F;

    // Drop enable at bit_cnt = 40 (right slot p = 8, bit 8 of 0F0F is 1)
    wait_high(2, 1100, n);
    check("tx_load_seen_2", 64'(n > 0), 64'h1);
    repeat (640) @(negedge clock);
    check("pre_drop_pins", 64'({AUD_BCLK, AUD_ADCLRCK, AUD_DACDAT}), 64'h3);
    enable = 1'b0;
    #1;
    c_rx = rxv_count;
    c_tx = txl_count;
    @(negedge clock);
    check("drop_pins_low", 64'({AUD_BCLK, AUD_ADCLRCK, AUD_DACLRCK, AUD_DACDAT}), 64'h0);
    toggles  = 0;
    prev_xck = AUD_XCK;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (AUD_XCK != prev_xck) toggles++;
      prev_xck = AUD_XCK;
    end
    check("xck_runs_disabled", 64'(toggles), 64'd4);
    repeat (100) @(negedge clock);
    #1;
    check("no_rx_valid_disabled", 64'(rxv_count - c_rx), 64'd0);
    check("no_tx_load_disabled", 64'(txl_count - c_tx), 64'd0);
    enable = 1'b1;
    #1;
    check("reenable_tx_load", 64'(tx_load), 64'h1);
    wait_high(3, 2000, n);
    check("reenable_rx_latency", 64'(n), 64'd777);
    check("reenable_rx_left", 64'(rx_left), 64'h7FFF);
    check("reenable_rx_right", 64'(rx_right), 64'h8000);

    // Asynchronous reset mid-frame
    repeat (300) @(negedge clock);
    #5;
    reset_n = 1'b0;
    #1;
    check("async_reset_outputs", 64'(out_vec()), 64'h0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    wait_high(3, 2000, n);
    check("reset_rx_latency", 64'(n), 64'd777);
    check("reset_rx_left", 64'(rx_left), 64'h7FFF);
    check("reset_rx_right", 64'(rx_right), 64'h8000);

    #1;
    check("no_coincide", 64'(coincide), 64'h0);
    check("single_cycle_rx_valid", 64'(multi_high), 64'h0);
    check("lrck_equal", 64'(lr_diff), 64'h0);
    check("dac_idle_bits_end", 64'(extra_ones), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
